// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: widths, FSM encoding,
// port indices and the read-return tag.
package dmem_arbiter_pkg;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 16;

  localparam logic [0:0] ARB    = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

  // Captured on every read grant; returned as rvalid on the following cycle
  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
);

  logic          m0_req;
  logic          m0_we;
  logic          m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester and memory view
  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on contention the port not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt_c
);

  always_comb begin
    gnt_c = 2'b00;
    case (req)
      2'b01:   gnt_c = 2'b01;
      2'b10:   gnt_c = 2'b10;
      2'b11:   gnt_c = last ? 2'b01 : 2'b10;
      default: gnt_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU port (0) and the loader/debug
// port (1): round-robin grants, optional ownership lock, one-cycle tagged read return.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  logic [0:0] state, state_nxt;
  logic       owner, owner_nxt;
  logic       last, last_nxt;
  rd_tag_t    tag, tag_nxt;

  logic [1:0] req;
  logic [1:0] lock;
  logic [1:0] rr_gnt;
  logic [1:0] gnt;
  logic       hold;

  assign req  = reset ? 2'b00 : {bus.m1_req, bus.m0_req};
  assign lock = {bus.m1_lock, bus.m0_lock};

  rr_pick2 u_pick (
    .req   (req),
    .last  (last),
    .gnt_c (rr_gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB;
      owner <= P_CPU;
      last  <= P_DBG;
      tag   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      tag   <= tag_nxt;
    end
  end

  // A locked owner that has dropped both req and lock releases in the same cycle,
  // so the other port can be granted immediately.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    tag_nxt   = '0;
    gnt       = 2'b00;
    hold      = (state == LOCKED) && (req[owner] || lock[owner]);

    if (hold) begin
      gnt = req[owner] ? port_onehot(owner) : 2'b00;
    end else begin
      gnt = rr_gnt;
    end

    if (gnt != 2'b00) begin
      last_nxt      = gnt[1];
      tag_nxt.valid = !(gnt[1] ? bus.m1_we : bus.m0_we);
      tag_nxt.port  = gnt[1];
      if (lock[gnt[1]]) begin
        state_nxt = LOCKED;
        owner_nxt = gnt[1];
      end else begin
        state_nxt = ARB;
      end
    end else if (!hold) begin
      state_nxt = ARB;
    end
  end

  assign bus.m0_gnt = gnt[0];
  assign bus.m1_gnt = gnt[1];
  assign bus.mem_en = |gnt;

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt[0]) begin
      bus.mem_we    = bus.m0_we;
      bus.mem_addr  = bus.m0_addr;
      bus.mem_wdata = bus.m0_wdata;
    end else if (gnt[1]) begin
      bus.mem_we    = bus.m1_we;
      bus.mem_addr  = bus.m1_addr;
      bus.mem_wdata = bus.m1_wdata;
    end
  end

  assign bus.m0_rvalid = tag.valid && (tag.port == P_CPU);
  assign bus.m1_rvalid = tag.valid && (tag.port == P_DBG);
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : DW'(0);
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : DW'(0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous memory model and a read-return scoreboard.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        port;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  exp_t        sb[$];
  logic [15:0] mem    [logic [15:0]];
  logic [15:0] shadow [logic [15:0]];

  dmem_arbiter_if #(.AW(16), .DW(16)) bus ();

  dmem_arbiter #(.AW(16), .DW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return 16'hA000 ^ a;
  endfunction

  // Synchronous single-port memory: read data valid the cycle after the access
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      else bus.mem_rdata <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : init_val(bus.mem_addr);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_m0(input logic r, input logic w, input logic l,
                        input logic [15:0] a, input logic [15:0] d);
    bus.m0_req = r; bus.m0_we = w; bus.m0_lock = l; bus.m0_addr = a; bus.m0_wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic l,
                        input logic [15:0] a, input logic [15:0] d);
    bus.m1_req = r; bus.m1_we = w; bus.m1_lock = l; bus.m1_addr = a; bus.m1_wdata = d;
  endtask

  // One cycle: check read return and grant/mem outputs at negedge, then advance
  task automatic step(input string tag, input logic [1:0] eg);
    exp_t        e;
    logic        ewe;
    logic [15:0] ea, ed;
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ".rvalid"}, {30'd0, bus.m1_rvalid, bus.m0_rvalid},
            {30'd0, (e.port ? 2'b10 : 2'b01)});
      check({tag, ".rdata"}, 32'(e.port ? bus.m1_rdata : bus.m0_rdata), 32'(e.data));
      check({tag, ".rdata_other"}, 32'(e.port ? bus.m0_rdata : bus.m1_rdata), 32'd0);
    end else begin
      check({tag, ".rvalid"}, {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
      check({tag, ".rdata"}, {bus.m1_rdata, bus.m0_rdata}, 32'd0);
    end
    check({tag, ".gnt"}, {30'd0, bus.m1_gnt, bus.m0_gnt}, {30'd0, eg});
    ewe = 1'b0; ea = '0; ed = '0;
    if (eg[0]) begin
      ewe = bus.m0_we; ea = bus.m0_addr; ed = bus.m0_wdata;
    end else if (eg[1]) begin
      ewe = bus.m1_we; ea = bus.m1_addr; ed = bus.m1_wdata;
    end
    check({tag, ".mem_en_we"}, {30'd0, bus.mem_en, bus.mem_we}, {30'd0, |eg, ewe});
    check({tag, ".mem_addr_wdata"}, {bus.mem_addr, bus.mem_wdata}, {ea, ed});
    if (eg != 2'b00) begin
      if (ewe) begin
        shadow[ea] = ed;
      end else begin
        e.port = eg[1];
        e.data = shadow.exists(ea) ? shadow[ea] : init_val(ea);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.mem_rdata = '0;
    // Reset held with both ports requesting: everything stays quiet
    set_m0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    set_m1(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    step("rst_hold0", 2'b00);
    step("rst_hold1", 2'b00);
    reset = 1'b0;

    // Round-robin with both ports reading continuously
    step("rr0", 2'b01);
    step("rr1", 2'b10);
    step("rr2", 2'b01);
    step("rr3", 2'b10);
    set_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_m1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step("rr_drain", 2'b00);

    // Write routing: port 0 writes, port 1 reads it back
    set_m0(1'b1, 1'b1, 1'b0, 16'h0007, 16'hBEEF);
    step("wr7", 2'b01);
    set_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_m1(1'b1, 1'b0, 1'b0, 16'h0007, 16'h0000);
    step("rd7", 2'b10);
    set_m1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step("rd7_ret", 2'b00);

    // Lock: port 1 keeps ownership across two writes while port 0 waits
    set_m0(1'b1, 1'b0, 1'b0, 16'h0011, 16'h0000);
    step("lk_pre", 2'b01);
    set_m0(1'b1, 1'b0, 1'b0, 16'h0012, 16'h0000);
    set_m1(1'b1, 1'b1, 1'b1, 16'h0004, 16'h1111);
    step("lk_w4", 2'b10);
    set_m1(1'b1, 1'b1, 1'b0, 16'h0005, 16'h2222);
    step("lk_w5", 2'b10);
    set_m1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step("lk_rel", 2'b01);
    set_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_m1(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000);
    step("lk_rb4", 2'b10);
    set_m1(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000);
    step("lk_rb5", 2'b10);
    set_m1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step("lk_drain", 2'b00);

    // Idle locked owner blocks port 1 until the lock drops
    set_m0(1'b1, 1'b0, 1'b1, 16'h0013, 16'h0000);
    step("il_lock", 2'b01);
    set_m0(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    set_m1(1'b1, 1'b0, 1'b0, 16'h0021, 16'h0000);
    for (int i = 0; i < 3; i++) step("il_wait", 2'b00);
    set_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step("il_free", 2'b10);
    set_m1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step("il_drain", 2'b00);

    // Reset mid-read: in-flight tag dropped, last returns to 1
    set_m0(1'b1, 1'b0, 1'b1, 16'h0014, 16'h0000);
    step("mr_rd", 2'b01);
    set_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    reset = 1'b1;
    sb.delete();
    step("mr_rst0", 2'b00);
    step("mr_rst1", 2'b00);
    reset = 1'b0;
    step("mr_post", 2'b00);
    set_m0(1'b1, 1'b0, 1'b0, 16'h0015, 16'h0000);
    set_m1(1'b1, 1'b0, 1'b0, 16'h0025, 16'h0000);
    step("mr_rr0", 2'b01);
    step("mr_rr1", 2'b10);
    set_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_m1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step("mr_drain", 2'b00);

    // Reset releases a held lock even with the owner's lock still high
    set_m0(1'b1, 1'b0, 1'b1, 16'h0016, 16'h0000);
    step("mr2_lock", 2'b01);
    set_m0(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    reset = 1'b1;
    sb.delete();
    step("mr2_rst", 2'b00);
    reset = 1'b0;
    set_m1(1'b1, 1'b0, 1'b0, 16'h0026, 16'h0000);
    step("mr2_unlock", 2'b10);
    set_m0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_m1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step("mr2_drain", 2'b00);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port 16-bit data memory between the CPU data port (port 0) and the loader/debug port (port 1). It sits between the processor core and data memory inside `top`. The CPU's `memwrite`/`dataadr`/`writedata` become port 0 once this block is inserted. Arbitration is round-robin, with an optional lock that keeps ownership for multi-access bursts.

## Interface
Parameters:
- `AW`, 16: address width.
- `DW`, 16: data width.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `m0_req`, `m1_req`  in  1: access request; held with fields stable until granted.
- `m0_we`, `m1_we`  in  1: 1 = write, 0 = read.
- `m0_lock`, `m1_lock`  in  1: keep ownership after this access.
- `m0_addr`, `m1_addr`  in  AW: word address.
- `m0_wdata`, `m1_wdata`  in  DW: write data.
- `m0_gnt`, `m1_gnt`  out  1: access accepted this cycle.
- `m0_rvalid`, `m1_rvalid`  out  1: read data valid; one-cycle pulse.
- `m0_rdata`, `m1_rdata`  out  DW: read data, qualified by rvalid.
- `mem_en`  out  1: memory access this cycle.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  AW: memory address.
- `mem_wdata`  out  DW: memory write data.
- `mem_rdata`  in  DW: synchronous read data, valid the cycle after `mem_en && !mem_we`.

## Operation
- **FSM states**
  - `ARB`: grant the active requester; if both request, grant the one not granted last.
  - `LOCKED(owner)`: only the owner can be granted; the other requester waits.
- **Transitions**
  - `ARB` → `LOCKED(n)`: on a grant to n with `mn_lock=1`.
  - `LOCKED(n)` → `ARB`: on a grant to n with `mn_lock=0`, or any cycle with `mn_req=0 && mn_lock=0`.
  - A locked owner idling with lock high keeps the lock.
- **Round-robin pointer `last`**: updated to the granted port on every grant. Reset value 1, so port 0 wins the first contest.
- **Grant**: combinational in the request cycle. At most one gnt high per cycle. `mem_en = m0_gnt | m1_gnt`; mem_we/addr/wdata are muxed from the granted port.
- **Read return**: a registered 2-bit tag (valid, port) captures each read grant. On the next cycle, the tagged port's rvalid=1 and its rdata=`mem_rdata`. The untagged port's rdata is 0.
- **Writes**: complete in the grant cycle; no rvalid is generated.
- **Back-to-back accesses** are allowed: a new grant may issue in the same cycle a previous read returns.

## Timing
- **Reset values**:
  - gnt, rvalid, `mem_en`, `mem_we`: 0.
  - `mem_addr`, `mem_wdata`, rdata: 0.
  - Internal: state=`ARB`, `last`=1, tag invalid.
- **Reset mid-operation**: an in-flight read tag is discarded, so no rvalid appears after reset deasserts. The lock is released.
- **Latency**:
  - Grant: 0 cycles from req when the resource is free.
  - Read data: 1 cycle after grant.
- **Throughput**: 1 access per cycle. With both requesting continuously and no lock, grants alternate 0,1,0,1.
- **Worst-case wait** for an unlocked contender: 1 cycle.
- **Locked owner**: may monopolise the memory; starvation of the other port is by design.
- Requests while `reset=1` are ignored.

## Structure
- Shared package holds:
  - `AW`/`DW` defaults.
  - The state encoding `ARB=1'b0`, `LOCKED=1'b1`, with the owner held in a separate 1-bit register.
  - The port index constants `P_CPU=0`, `P_DBG=1`.
- One natural sub-module: `rr_pick2`, a combinational 2-way round-robin picker (req[1:0], last → gnt one-hot).
- The FSM, read tag and muxes live in `dmem_arbiter`.

## Test plan
- **Reset**: hold reset with both requests high → all outputs 0. Release → first cycle grants port 0.
- **Round-robin**: both reads at 0x0010 (port 0) and 0x0020 (port 1), held 4 cycles → grants 0,1,0,1. Each rvalid arrives one cycle after its grant, with rdata from the matching address.
- **Lock**: port 1 writes 0x0004 then 0x0005 with lock=1 on the first, while port 0 requests throughout → port 0 blocked until the cycle after port 1's unlocked grant.
- **Write routing**: port 0 writes 0xBEEF at 0x0007, then port 1 reads 0x0007 → `mem_we` pulses once, and m1_rdata=0xBEEF with m1_rvalid one cycle later.
- **Reset mid-read**: port 0 read granted, then reset asserted in the next cycle → m0_rvalid stays 0. After release, state is `ARB` and `last`=1.
- **Idle locked owner**: port 0 locks, then drops req with lock held for 3 cycles while port 1 requests → no grant to port 1. Port 0 drops lock → port 1 granted the same cycle.
